hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Stall/flush controller for the non-forwarding 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Keeps a shadow of destination registers in flight in EX/MEM/WB.
- Detects RAW hazards against the instruction in ID, sequences stalls, bubbles and mispredict flushes, and honours a whole-pipeline freeze from the LSU.
- Exports debug hazard flag and saturating performance counters.

Parameters:
- WB_BYPASS, 0, 1 = register file is write-through, so WB-stage rd never causes a hazard; 0 = WB rd also checked.
- CNT_W, 32, width of each performance counter.

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_id_vld  in  1  ID holds a valid instruction
- i_id_rs1  in  5  ID source register 1
- i_id_rs2  in  5  ID source register 2
- i_id_rs1_use  in  1  ID reads rs1
- i_id_rs2_use  in  1  ID reads rs2
- i_id_rd  in  5  ID destination register
- i_id_rd_wren  in  1  ID writes rd
- i_ex_mispred  in  1  EX resolved branch/jump mispredict (redirect this cycle)
- i_lsu_busy  in  1  data memory not ready; freeze whole pipeline
- i_cnt_clr  in  1  synchronous clear of all counters
- o_stall_pc  out  1  hold PC and IF/ID register
- o_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB registers
- o_flush_ifid  out  1  load NOP into IF/ID
- o_flush_idex  out  1  load bubble into ID/EX
- o_data_hazard  out  1  RAW hazard detected for ID (debug)
- o_stall_cnt  out  CNT_W  cycles lost to RAW stalls
- o_flush_cnt  out  CNT_W  mispredict flushes
- o_retire_cnt  out  CNT_W  valid instructions leaving WB

Behaviour:
- Shadow stages EX, MEM, WB, each holding {vld, rd, wren}. On reset all are cleared to 0; all outputs are 0 and all counters are 0.
- Combinational hazard: for a stage S, match(S) = S.vld & S.wren & (S.rd != 0) & ((rs1_use & rs1 == S.rd) | (rs2_use & rs2 == S.rd)).
- o_data_hazard = i_id_vld & (match(EX) | match(MEM) | (match(WB) & !WB_BYPASS)).
- x0 never hazards.
- Priority of outputs, highest first:
  1. i_lsu_busy: o_freeze=1, o_stall_pc=1, both flushes 0. Shadow and counters hold. A mispredict present during freeze is deferred, because EX is held and i_ex_mispred stays asserted.
  2. i_ex_mispred: o_flush_ifid=1, o_flush_idex=1, o_stall_pc=0. The hazard is ignored and not counted. o_flush_cnt += 1.
  3. o_data_hazard: o_stall_pc=1, o_flush_idex=1 (bubble), o_freeze=0. o_stall_cnt += 1.
  4. Otherwise all control outputs are 0.
- Shadow update when not frozen:
  - WB <= MEM and MEM <= EX.
  - EX <= {i_id_vld, i_id_rd, i_id_rd_wren} unless mispred or hazard, in which case EX <= 0.
- o_retire_cnt increments when not frozen and WB.vld=1, i.e. on the cycle WB is overwritten.
- Hazard latency: a dependent instruction in ID stalls 3 cycles behind its producer in EX (2 cycles if WB_BYPASS=1), then issues the following cycle.
- Counters saturate at all-ones.
- i_cnt_clr zeroes counters that cycle; it overrides an increment in the same cycle.
- Control outputs are combinational from current inputs and shadow; shadow and counters are registered.
- Reset mid-stall: shadow cleared and the stall drops immediately (async); counters read 0.

Test Plan:
- Back-to-back RAW, WB_BYPASS=0: producer addi x5 followed by add x6,x5,x1 → o_data_hazard/o_stall_pc high for exactly 3 cycles, 3 bubbles into EX, o_stall_cnt=3; with WB_BYPASS=1 the same sequence gives 2 cycles, o_stall_cnt=2.
- x0 and non-use: producer rd=x0 followed by a consumer reading x0, and a consumer with rs2_use=0 but rs2 matching → no stall, o_stall_cnt=0.
- Mispredict coincident with hazard: i_ex_mispred=1 while ID depends on EX rd → flush_ifid=flush_idex=1, o_stall_pc=0, o_flush_cnt=1, o_stall_cnt unchanged; next cycle EX shadow vld=0.
- LSU freeze during hazard: i_lsu_busy held for 4 cycles mid-stall → o_freeze=1 for 4 cycles, shadow and counters frozen, remaining stall cycles resume afterwards for the same total stall count.
- Counter saturation/clear, CNT_W=4: 20 hazard cycles → o_stall_cnt=15; i_cnt_clr together with a hazard → 0 the next cycle.
- Async reset asserted mid-stall between clock edges → all outputs 0 immediately; after release an independent instruction issues with no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW stall, mispredict flush and LSU freeze control for a
// non-forwarding 5-stage RV32I pipeline, plus saturating perf counters.
module hazard_ctrl #(
  parameter bit          WB_BYPASS = 1'b0,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_id_vld,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_use,
  input  logic             i_id_rs2_use,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_rd_wren,
  input  logic             i_ex_mispred,
  input  logic             i_lsu_busy,
  input  logic             i_cnt_clr,
  output logic             o_stall_pc,
  output logic             o_freeze,
  output logic             o_flush_ifid,
  output logic             o_flush_idex,
  output logic             o_data_hazard,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_retire_cnt
);

  localparam int unsigned REG_W = 5;

  // Shadow of {vld, rd, wren} for the instructions in EX, MEM and WB.
  logic             ex_vld_q, ex_vld_d, ex_wren_q, ex_wren_d;
  logic             mem_vld_q, mem_vld_d, mem_wren_q, mem_wren_d;
  logic             wb_vld_q, wb_vld_d, wb_wren_q, wb_wren_d;
  logic [REG_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic hit_ex_c, hit_mem_c, hit_wb_c, data_hazard_c, advance_c;

  // True when a shadow stage will write a register the ID instruction reads.
  function automatic logic stage_match(
    input logic             vld,
    input logic             wren,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs1,
    input logic             rs1_use,
    input logic [REG_W-1:0] rs2,
    input logic             rs2_use
  );
    return vld & wren & (rd != '0) &
           ((rs1_use & (rs1 == rd)) | (rs2_use & (rs2 == rd)));
  endfunction

  // Saturating increment; clear wins over increment.
  function automatic logic [CNT_W-1:0] cnt_next(
    input logic [CNT_W-1:0] cnt,
    input logic             inc,
    input logic             clr
  );
    if (clr)                return '0;
    else if (inc && !(&cnt)) return cnt + CNT_W'(1);
    else                     return cnt;
  endfunction

  // RAW hazard detection against the ID instruction.
  always_comb begin
    hit_ex_c  = stage_match(ex_vld_q, ex_wren_q, ex_rd_q,
                            i_id_rs1, i_id_rs1_use, i_id_rs2, i_id_rs2_use);
    hit_mem_c = stage_match(mem_vld_q, mem_wren_q, mem_rd_q,
                            i_id_rs1, i_id_rs1_use, i_id_rs2, i_id_rs2_use);
    hit_wb_c  = stage_match(wb_vld_q, wb_wren_q, wb_rd_q,
                            i_id_rs1, i_id_rs1_use, i_id_rs2, i_id_rs2_use);
    data_hazard_c = i_id_vld & (hit_ex_c | hit_mem_c | (hit_wb_c & ~WB_BYPASS));
  end

  // Prioritised pipeline control: freeze > mispredict flush > RAW stall.
  always_comb begin
    o_stall_pc    = 1'b0;
    o_freeze      = 1'b0;
    o_flush_ifid  = 1'b0;
    o_flush_idex  = 1'b0;
    o_data_hazard = i_reset & data_hazard_c;
    if (i_reset) begin
      if (i_lsu_busy) begin
        o_freeze   = 1'b1;
        o_stall_pc = 1'b1;
      end else if (i_ex_mispred) begin
        o_flush_ifid = 1'b1;
        o_flush_idex = 1'b1;
      end else if (data_hazard_c) begin
        o_stall_pc   = 1'b1;
        o_flush_idex = 1'b1;
      end
    end
  end

  // Shadow advance and counter next-state; everything holds while frozen.
  always_comb begin
    advance_c  = ~i_lsu_busy;
    ex_vld_d   = ex_vld_q;
    ex_rd_d    = ex_rd_q;
    ex_wren_d  = ex_wren_q;
    mem_vld_d  = mem_vld_q;
    mem_rd_d   = mem_rd_q;
    mem_wren_d = mem_wren_q;
    wb_vld_d   = wb_vld_q;
    wb_rd_d    = wb_rd_q;
    wb_wren_d  = wb_wren_q;
    if (advance_c) begin
      wb_vld_d   = mem_vld_q;
      wb_rd_d    = mem_rd_q;
      wb_wren_d  = mem_wren_q;
      mem_vld_d  = ex_vld_q;
      mem_rd_d   = ex_rd_q;
      mem_wren_d = ex_wren_q;
      if (i_ex_mispred || data_hazard_c) begin
        ex_vld_d  = 1'b0;
        ex_rd_d   = '0;
        ex_wren_d = 1'b0;
      end else begin
        ex_vld_d  = i_id_vld;
        ex_rd_d   = i_id_rd;
        ex_wren_d = i_id_rd_wren;
      end
    end
    stall_cnt_d  = cnt_next(stall_cnt_q,
                            advance_c & ~i_ex_mispred & data_hazard_c, i_cnt_clr);
    flush_cnt_d  = cnt_next(flush_cnt_q, advance_c & i_ex_mispred, i_cnt_clr);
    retire_cnt_d = cnt_next(retire_cnt_q, advance_c & wb_vld_q, i_cnt_clr);
  end

  // Shadow and counter registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ex_vld_q     <= 1'b0;
      ex_rd_q      <= '0;
      ex_wren_q    <= 1'b0;
      mem_vld_q    <= 1'b0;
      mem_rd_q     <= '0;
      mem_wren_q   <= 1'b0;
      wb_vld_q     <= 1'b0;
      wb_rd_q      <= '0;
      wb_wren_q    <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      ex_vld_q     <= ex_vld_d;
      ex_rd_q      <= ex_rd_d;
      ex_wren_q    <= ex_wren_d;
      mem_vld_q    <= mem_vld_d;
      mem_rd_q     <= mem_rd_d;
      mem_wren_q   <= mem_wren_d;
      wb_vld_q     <= wb_vld_d;
      wb_rd_q      <= wb_rd_d;
      wb_wren_q    <= wb_wren_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign o_stall_cnt  = stall_cnt_q;
  assign o_flush_cnt  = flush_cnt_q;
  assign o_retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: two hazard_ctrl instances (WB checked with 4-bit counters,
// WB write-through with 32-bit counters) driven by the same directed vectors
// and checked every cycle against an in-flight-instruction age model.
module tb_hazard_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_id_vld, i_id_rs1_use, i_id_rs2_use, i_id_rd_wren;
  logic [4:0] i_id_rs1, i_id_rs2, i_id_rd;
  logic       i_ex_mispred, i_lsu_busy, i_cnt_clr;

  logic        stall_pc0, freeze0, fifid0, fidex0, haz0;
  logic        stall_pc1, freeze1, fifid1, fidex1, haz1;
  logic [3:0]  sc0, fc0, rc0;
  logic [31:0] sc1, fc1, rc1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(4)) dut0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_id_vld(i_id_vld),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_rs1_use(i_id_rs1_use), .i_id_rs2_use(i_id_rs2_use),
    .i_id_rd(i_id_rd), .i_id_rd_wren(i_id_rd_wren),
    .i_ex_mispred(i_ex_mispred), .i_lsu_busy(i_lsu_busy), .i_cnt_clr(i_cnt_clr),
    .o_stall_pc(stall_pc0), .o_freeze(freeze0), .o_flush_ifid(fifid0),
    .o_flush_idex(fidex0), .o_data_hazard(haz0),
    .o_stall_cnt(sc0), .o_flush_cnt(fc0), .o_retire_cnt(rc0)
  );

  hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(32)) dut1 (
    .i_clk(i_clk), .i_reset(i_reset), .i_id_vld(i_id_vld),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_rs1_use(i_id_rs1_use), .i_id_rs2_use(i_id_rs2_use),
    .i_id_rd(i_id_rd), .i_id_rd_wren(i_id_rd_wren),
    .i_ex_mispred(i_ex_mispred), .i_lsu_busy(i_lsu_busy), .i_cnt_clr(i_cnt_clr),
    .o_stall_pc(stall_pc1), .o_freeze(freeze1), .o_flush_ifid(fifid1),
    .o_flush_idex(fidex1), .o_data_hazard(haz1),
    .o_stall_cnt(sc1), .o_flush_cnt(fc1), .o_retire_cnt(rc1)
  );

  // Model: every issued instruction per instance with its age past ID
  // (1 = EX, 2 = MEM, 3 = WB); it retires when it ages beyond WB.
  typedef struct {
    int         inst;
    int         age;
    logic [4:0] rd;
    logic       wren;
  } ins_t;

  ins_t        mq[$];
  int unsigned m_stall[2]  = '{0, 0};
  int unsigned m_flush[2]  = '{0, 0};
  int unsigned m_retire[2] = '{0, 0};

  function automatic int unsigned cap(input int b);
    return (b == 0) ? 32'd15 : 32'hFFFF_FFFF;
  endfunction

  // A producer is visible to ID up to WB, or only up to MEM with write-through.
  function automatic logic m_haz(input int b);
    int oldest;
    oldest = (b == 1) ? 2 : 3;
    if (!i_id_vld) return 1'b0;
    foreach (mq[i]) begin
      if (mq[i].inst == b && mq[i].wren && mq[i].rd != 5'd0 && mq[i].age <= oldest &&
          ((i_id_rs1_use && i_id_rs1 == mq[i].rd) || (i_id_rs2_use && i_id_rs2 == mq[i].rd)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // Expected {stall_pc, freeze, flush_ifid, flush_idex, data_hazard}.
  function automatic logic [4:0] m_ctrl(input int b);
    logic h;
    h = m_haz(b);
    if (!i_reset)     return 5'b00000;
    if (i_lsu_busy)   return {4'b1100, h};
    if (i_ex_mispred) return {4'b0011, h};
    if (h)            return 5'b10011;
    return 5'b00000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update on each clock edge; reset clears it asynchronously.
  always @(posedge i_clk or negedge i_reset) begin
    logic hz[2];
    logic ret[2];
    ins_t nq[$];
    ins_t e;
    if (!i_reset) begin
      mq.delete();
      for (int b = 0; b < 2; b++) begin
        m_stall[b] = 0; m_flush[b] = 0; m_retire[b] = 0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        hz[b]  = m_haz(b);
        ret[b] = 1'b0;
      end
      if (!i_lsu_busy) begin
        nq.delete();
        foreach (mq[i]) begin
          e = mq[i];
          if (e.age >= 3) ret[e.inst] = 1'b1;
          else begin
            e.age++;
            nq.push_back(e);
          end
        end
        for (int b = 0; b < 2; b++) begin
          if (i_id_vld && !i_ex_mispred && !hz[b]) begin
            e.inst = b; e.age = 1; e.rd = i_id_rd; e.wren = i_id_rd_wren;
            nq.push_back(e);
          end
        end
        mq = nq;
      end
      for (int b = 0; b < 2; b++) begin
        if (i_cnt_clr) begin
          m_stall[b] = 0; m_flush[b] = 0; m_retire[b] = 0;
        end else begin
          if (!i_lsu_busy && i_ex_mispred && m_flush[b] < cap(b)) m_flush[b]++;
          if (!i_lsu_busy && !i_ex_mispred && hz[b] && m_stall[b] < cap(b)) m_stall[b]++;
          if (ret[b] && m_retire[b] < cap(b)) m_retire[b]++;
        end
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge i_clk) begin
    chk("ctrl_b0",   32'({stall_pc0, freeze0, fifid0, fidex0, haz0}), 32'(m_ctrl(0)));
    chk("ctrl_b1",   32'({stall_pc1, freeze1, fifid1, fidex1, haz1}), 32'(m_ctrl(1)));
    chk("stall_b0",  32'(sc0), m_stall[0]);
    chk("flush_b0",  32'(fc0), m_flush[0]);
    chk("retire_b0", 32'(rc0), m_retire[0]);
    chk("stall_b1",  sc1, m_stall[1]);
    chk("flush_b1",  fc1, m_flush[1]);
    chk("retire_b1", rc1, m_retire[1]);
  end

  task automatic set_in(input logic vld, input logic [4:0] rs1, input logic r1u,
                        input logic [4:0] rs2, input logic r2u,
                        input logic [4:0] rd, input logic wr);
    i_id_vld = vld; i_id_rs1 = rs1; i_id_rs1_use = r1u;
    i_id_rs2 = rs2; i_id_rs2_use = r2u; i_id_rd = rd; i_id_rd_wren = wr;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_cnt();
    i_cnt_clr = 1'b1;
    tick();
    i_cnt_clr = 1'b0;
  endtask

  initial begin
    i_reset = 1'b0;
    i_ex_mispred = 1'b0; i_lsu_busy = 1'b0; i_cnt_clr = 1'b0;
    idle();
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ctrl_b0", 32'({stall_pc0, freeze0, fifid0, fidex0, haz0}), 32'd0);
    chk("rst_cnt_b0",  32'({sc0, fc0, rc0}), 32'd0);
    chk("rst_cnt_b1",  sc1 | fc1 | rc1, 32'd0);
    i_reset = 1'b1;
    tick();

    // Back-to-back RAW: addi x5,x1 then add x6,x5,x1 held in ID.
    set_in(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    tick();
    set_in(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1);
    repeat (4) tick();
    idle();
    repeat (4) tick();
    chk("raw_stall_b0", 32'(sc0), 32'd3);
    chk("raw_stall_b1", sc1, 32'd2);
    clear_cnt();
    chk("clr_stall_b0", 32'(sc0), 32'd0);

    // x0 producer/consumer and an unused rs2 that matches.
    set_in(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1);
    tick();
    set_in(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1);
    tick();
    set_in(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
    tick();
    set_in(1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 5'd8, 1'b1);
    tick();
    idle();
    repeat (4) tick();
    chk("x0_stall_b0", 32'(sc0), 32'd0);
    chk("x0_stall_b1", sc1, 32'd0);

    // Mispredict coinciding with a hazard on the EX producer.
    clear_cnt();
    set_in(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1);
    tick();
    set_in(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1);
    i_ex_mispred = 1'b1;
    #2;
    chk("mis_ctrl_b0", 32'({stall_pc0, freeze0, fifid0, fidex0, haz0}), 32'b00111);
    chk("mis_ctrl_b1", 32'({stall_pc1, freeze1, fifid1, fidex1, haz1}), 32'b00111);
    tick();
    i_ex_mispred = 1'b0;
    idle();
    chk("mis_flush_b0", 32'(fc0), 32'd1);
    chk("mis_stall_b0", 32'(sc0), 32'd0);
    repeat (4) tick();

    // LSU freeze for 4 cycles in the middle of a RAW stall.
    clear_cnt();
    set_in(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1);
    tick();
    set_in(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
    tick();
    i_lsu_busy = 1'b1;
    #2;
    chk("frz_ctrl_b0", 32'({stall_pc0, freeze0, fifid0, fidex0, haz0}), 32'b11001);
    chk("frz_stall_b0", 32'(sc0), 32'd1);
    tick();
    repeat (3) tick();
    chk("frz_hold_b0", 32'(sc0), 32'd1);
    i_lsu_busy = 1'b0;
    repeat (6) tick();
    idle();
    repeat (4) tick();
    chk("frz_total_b0", 32'(sc0), 32'd3);
    chk("frz_total_b1", sc1, 32'd2);

    // Self-dependent add x10,x10,x10 held in ID saturates the 4-bit counter.
    clear_cnt();
    set_in(1'b1, 5'd10, 1'b1, 5'd10, 1'b1, 5'd10, 1'b1);
    repeat (29) tick();
    chk("sat_stall_b0", 32'(sc0), 32'd15);
    i_cnt_clr = 1'b1;
    #2;
    chk("sat_haz_b0", 32'(haz0), 32'd1);
    tick();
    i_cnt_clr = 1'b0;
    chk("clr_haz_b0", 32'(sc0), 32'd0);
    idle();
    repeat (4) tick();

    // Asynchronous reset between clock edges in the middle of a stall.
    set_in(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1);
    tick();
    set_in(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1);
    tick();
    #2;
    i_reset = 1'b0;
    #1;
    chk("arst_ctrl_b0", 32'({stall_pc0, freeze0, fifid0, fidex0, haz0}), 32'd0);
    chk("arst_ctrl_b1", 32'({stall_pc1, freeze1, fifid1, fidex1, haz1}), 32'd0);
    chk("arst_cnt_b0",  32'({sc0, fc0, rc0}), 32'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    set_in(1'b1, 5'd13, 1'b1, 5'd14, 1'b1, 5'd15, 1'b1);
    #2;
    chk("post_rst_b0", 32'(stall_pc0), 32'd0);
    chk("post_rst_b1", 32'(stall_pc1), 32'd0);
    tick();
    idle();
    repeat (5) tick();
    chk("post_rst_retire_b0", 32'(rc0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
